accum_block_12bit: RTL
======================

// Module: accum_block_12bit
// PURPOSE
//  Block accumulator that sits downstream of the 12-bit ripple adder (add_12bit).
//  It takes a valid/ready stream of 12-bit samples and adds the running sum to each
//  sample through one add_12bit instance. The sum is mod 4096 and carry-out is discarded.
//  After N samples it presents the block sum, with a wrap flag, on a valid/ready output.
//  It feeds later stages that need per-block totals.
// PARAMETERS
//  N      8   samples per block; legal range 1..4096
//  CNT_W  -   localparam = max(1,$clog2(N)); width of the sample counter
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous, active-high reset
//  clr        in   1   synchronous abort; discards the partial block
//  in_valid   in   1   in_data is valid
//  in_ready   out  1   block accepts a sample this cycle
//  in_data    in   12  sample value, unsigned
//  out_valid  out  1   out_sum and out_wrap are valid
//  out_ready  in   1   consumer accepts the result
//  out_sum    out  12  block sum mod 4096
//  out_wrap   out  1   at least one addition in the block overflowed 4095
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge), in priority over every other input:
//    state=ACCUM, acc=0, cnt=0, wrap=0, out_valid=0, out_sum=0, out_wrap=0.
//  - Arithmetic: nxt = add_12bit(acc, in_data), 12 bits, carry-out lost.
//    The wrap condition for this sample is (nxt < acc), unsigned compare.
//  - ACCUM state:
//    - in_ready = ~clr. out_valid = 0.
//    - accept = in_valid & in_ready.
//    - On accept with cnt < N-1: acc<=nxt, cnt<=cnt+1, wrap<=wrap|wrapcond.
//    - On accept with cnt == N-1: out_sum<=nxt, out_wrap<=wrap|wrapcond,
//      acc<=0, cnt<=0, wrap<=0, state<=HOLD.
//    - clr=1: acc<=0, cnt<=0, wrap<=0. Any sample presented that cycle is not accepted.
//  - HOLD state:
//    - in_ready = 0. out_valid = 1.
//    - out_sum and out_wrap stay stable until the handshake completes.
//    - out_valid & out_ready -> state<=ACCUM. out_valid falls on the next cycle.
//    - clr is ignored in HOLD; a completed block is never dropped.
//  - Latency and throughput:
//    - out_valid rises 1 cycle after the Nth accepted sample.
//    - in_ready returns the cycle after the output handshake.
//    - Minimum N+1 cycles per block when out_ready is held high.
//  - N=1: every accepted sample goes straight to HOLD. out_sum = in_data, out_wrap = 0.
//  - in_valid may drop in mid-block; the partial acc and cnt are held indefinitely.
//  - Counter: cnt never exceeds N-1 and wraps to 0 only at block completion.
//  - Reset during HOLD discards the pending result (out_valid=0 on the next cycle).
// TESTING
//  T1 N=8: samples 1..8 back-to-back, out_ready=1
//     -> out_sum=36, out_wrap=0, out_valid high for 1 cycle, 1 cycle after the 8th accept.
//  T2 N=8: eight samples of 0x400
//     -> out_sum=0x000, out_wrap=1. Next block of eight 0x001 -> out_sum=8, out_wrap=0 (flag cleared).
//  T3 N=4: block done, out_ready=0 for 5 cycles
//     -> out_valid stays 1, out_sum stable, in_ready=0. On release, in_ready=1 the cycle after.
//  T4 N=4: accept 3 samples (0x111 each), then pulse clr
//     -> the partial is discarded. Next 4 samples of 0x001 -> out_sum=4.
//  T5 clr together with in_valid in ACCUM
//     -> in_ready=0 and the sample is not counted. clr in HOLD -> result still delivered.
//  T6 rst asserted in mid-block and in HOLD
//     -> next cycle: out_valid=0, out_sum=0, in_ready=1, and the count restarts from 0.
//  Scoreboard: reference model in the bench, random in_valid/out_ready, N in {1,3,8}.
//  Check handshake stability on every cycle.

Source files
------------

// File: rtl/accum_block_12bit.sv
// accum_block_12bit: block accumulator for a valid/ready stream of 12-bit samples.
// It sums N samples mod 4096 through one add_12bit ripple adder. The block sum
// and a wrap flag are then held on a valid/ready output until it is consumed.
//   clk, rst       : clock, synchronous active-high reset
//   clr            : abort the partial block (ignored while a result is pending)
//   in_valid/ready : sample handshake, in_data = 12-bit unsigned sample
//   out_valid/ready: result handshake, out_sum = block sum mod 4096,
//                    out_wrap = some addition in the block overflowed
// add_12bit: 12-bit ripple-carry adder (a_i + b_i), carry-out on cout_o.

module add_12bit (
  input  logic [11:0] a_i,
  input  logic [11:0] b_i,
  output logic [11:0] sum_o,
  output logic        cout_o
);
  logic [12:0] c;
  assign c[0] = 1'b0;
  for (genvar i = 0; i < 12; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end
  assign cout_o = c[12];
endmodule

module accum_block_12bit #(
  parameter int N = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_sum,
  output logic        out_wrap
);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t            state_q, state_d;
  logic [11:0]       acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wrap_q, wrap_d;
  logic [11:0]       sum_q, sum_d;
  logic              owrap_q, owrap_d;

  logic [11:0] nxt;
  logic        cout_unused;
  logic        wcond;
  logic        last;

  add_12bit u_add (
    .a_i   (acc_q),
    .b_i   (in_data),
    .sum_o (nxt),
    .cout_o(cout_unused)
  );

  // Overflow detected from the truncated result, so the adder carry is not needed.
  assign wcond = (nxt < acc_q);
  assign last  = (cnt_q == CNT_W'(N - 1));

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    wrap_d    = wrap_q;
    sum_d     = sum_q;
    owrap_d   = owrap_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready = ~clr;
        if (clr) begin
          acc_d  = '0;
          cnt_d  = '0;
          wrap_d = 1'b0;
        end else if (in_valid) begin
          if (last) begin
            sum_d   = nxt;
            owrap_d = wrap_q | wcond;
            acc_d   = '0;
            cnt_d   = '0;
            wrap_d  = 1'b0;
            state_d = HOLD;
          end else begin
            acc_d  = nxt;
            cnt_d  = cnt_q + CNT_W'(1);
            wrap_d = wrap_q | wcond;
          end
        end
      end
      HOLD: begin
        // Result stays registered; clr has no effect so the block is never dropped.
        out_valid = 1'b1;
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      sum_q   <= '0;
      owrap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      sum_q   <= sum_d;
      owrap_q <= owrap_d;
    end
  end

  assign out_sum  = sum_q;
  assign out_wrap = owrap_q;
endmodule
